// File: rtl/prbs_checker.sv
// prbs_checker: receive-side PRBS-7 (x^7+x^6+1) checker; self-syncs, reports lock and bit errors.
// Latency: all outputs are registered and update on the edge that samples the bit.
// Backpressure: none; one bit per clock when en=1, all state holds when en=0.
// Optional: define PRBS_CHECKER_BITCNT_EN to add the 32-bit bit_cnt output (locked valid bits).
module prbs_checker #(
  parameter int LOCK_COUNT    = 16,
  parameter int WINDOW        = 64,
  parameter int LOSS_THRESH   = 8,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in,
  input  logic                     en,
  input  logic                     clear,
  output logic                     locked,
  output logic                     err,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
`ifdef PRBS_CHECKER_BITCNT_EN
  ,
  output logic [31:0]              bit_cnt
`endif
);

  localparam logic [7:0]  LOCK_C = 8'(LOCK_COUNT);
  localparam logic [15:0] WIN_C  = 16'(WINDOW);
  localparam logic [15:0] LOSS_C = 16'(LOSS_THRESH);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [6:0]  lfsr;
  logic [2:0]  seed_cnt;
  logic [7:0]  match_cnt;
  logic [15:0] win_bits;
  logic [15:0] win_errs;

  logic        pred;
  logic        mism;
  logic [6:0]  seed_shift;
  logic        seed_done;
  logic        match_done;
  logic        loss;
  logic        win_end;
  logic        in_lock;

  // Predictor taps for x^7+x^6+1; in SEED the received bit itself is shifted in.
  assign pred       = lfsr[6] ^ lfsr[5];
  assign mism       = in ^ pred;
  assign seed_shift = {lfsr[5:0], in};
  assign seed_done  = (seed_cnt == 3'd6);
  assign match_done = ((match_cnt + 8'd1) == LOCK_C);
  assign loss       = mism && ((win_errs + 16'd1) == LOSS_C);
  assign win_end    = ((win_bits + 16'd1) == WIN_C);
  assign in_lock    = (state == LOCKED);
  assign locked     = in_lock;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: an all-zero seed cannot be tracked, so SEED repeats until a nonzero one.
  always_comb begin
    state_nxt = state;
    if (en) begin
      case (state)
        SEED: begin
          if (seed_done && (seed_shift != 7'd0)) state_nxt = VERIFY;
        end
        VERIFY: begin
          if (mism)            state_nxt = SEED;
          else if (match_done) state_nxt = LOCKED;
        end
        LOCKED: begin
          if (loss) state_nxt = SEED;
        end
        default: state_nxt = SEED;
      endcase
    end
  end

  // Predictor register and acquisition counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr      <= '0;
      seed_cnt  <= '0;
      match_cnt <= '0;
    end else if (en) begin
      case (state)
        SEED: begin
          lfsr      <= seed_shift;
          seed_cnt  <= seed_done ? 3'd0 : seed_cnt + 3'd1;
          match_cnt <= '0;
        end
        VERIFY: begin
          lfsr <= {lfsr[5:0], pred};
          if (mism || match_done) begin
            seed_cnt  <= '0;
            match_cnt <= '0;
          end else begin
            match_cnt <= match_cnt + 8'd1;
          end
        end
        default: begin
          lfsr      <= {lfsr[5:0], pred};
          seed_cnt  <= '0;
          match_cnt <= '0;
        end
      endcase
    end
  end

  // Error pulse, window bookkeeping and saturating error count; clear overrides counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err      <= 1'b0;
      err_cnt  <= '0;
      win_bits <= '0;
      win_errs <= '0;
    end else begin
      err <= en && in_lock && mism;
      if (en && in_lock) begin
        // Loss of lock and window end both restart the window; loss also changes state.
        if (loss || win_end) begin
          win_bits <= '0;
          win_errs <= '0;
        end else begin
          win_bits <= win_bits + 16'd1;
          win_errs <= win_errs + {15'd0, mism};
        end
        if (mism && (err_cnt != '1)) err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
      end
      if (clear) begin
        err_cnt  <= '0;
        win_bits <= '0;
        win_errs <= '0;
      end
    end
  end

`ifdef PRBS_CHECKER_BITCNT_EN
  // Saturating count of valid bits sampled while locked; survives loss of lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (clear) begin
      bit_cnt <= '0;
    end else if (en && in_lock && (bit_cnt != 32'hFFFF_FFFF)) begin
      bit_cnt <= bit_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: directed PRBS-7 streams with per-cycle expectations on a scoreboard.
// A second instance with a 4-bit error counter shares the stimulus to show saturation at 15.
// Stimulus drives on the falling edge; the monitor compares 1 time unit after each rising edge.
module tb_prbs_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in = 1'b0;
  logic       en = 1'b0;
  logic       clear = 1'b0;
  logic       locked, err;
  logic [15:0] err_cnt;
  logic       locked_s, err_s;
  logic [3:0] err_cnt_s;
`ifdef PRBS_CHECKER_BITCNT_EN
  logic [31:0] bit_cnt, bit_cnt_s;
`endif

  always #5 clk = ~clk;

  prbs_checker dut (
    .clk(clk), .rst(rst), .in(in), .en(en), .clear(clear),
    .locked(locked), .err(err), .err_cnt(err_cnt)
`ifdef PRBS_CHECKER_BITCNT_EN
    , .bit_cnt(bit_cnt)
`endif
  );

  prbs_checker #(.ERR_CNT_WIDTH(4)) dut_s (
    .clk(clk), .rst(rst), .in(in), .en(en), .clear(clear),
    .locked(locked_s), .err(err_s), .err_cnt(err_cnt_s)
`ifdef PRBS_CHECKER_BITCNT_EN
    , .bit_cnt(bit_cnt_s)
`endif
  );

  typedef struct {
    logic   l;
    logic   e;
    int     c;
    longint bc;
    int     ph;
    int     cyc;
  } exp_t;

  exp_t       q[$];
  int         tests = 0;
  int         fails = 0;
  int         ec = 0;
  longint     exp_bits = 0;
  logic       cur_locked = 1'b0;
  int         phase = 0;
  int         cyc = 0;
  logic [6:0] g = 7'h7F;

  function automatic void check(input string nm, input int ph, input int cy,
                                input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s ph%0d cyc%0d: got %0d want %0d", nm, ph, cy, act, want);
    end
  endfunction

  // Reference PRBS-7 generator, advanced only on valid bits.
  function automatic logic gen_bit();
    logic b;
    b = g[6] ^ g[5];
    g = {g[5:0], b};
    return b;
  endfunction

  task automatic step(input logic b, input logic e, input logic c, input logic xl, input logic xe);
    exp_t x;
    @(negedge clk);
    in = b;
    en = e;
    clear = c;
    if (c) exp_bits = 0;
    else if (e && cur_locked) exp_bits++;
    cur_locked = xl;
    x.l = xl; x.e = xe; x.c = ec; x.bc = exp_bits; x.ph = phase; x.cyc = cyc;
    cyc++;
    q.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    clear = 1'b0;
    #1;
    check("rst_locked", phase, cyc, 64'(locked), 64'd0);
    check("rst_err", phase, cyc, 64'(err), 64'd0);
    check("rst_err_cnt", phase, cyc, 64'(err_cnt), 64'd0);
    check("rst_err_cnt_s", phase, cyc, 64'(err_cnt_s), 64'd0);
`ifdef PRBS_CHECKER_BITCNT_EN
    check("rst_bit_cnt", phase, cyc, 64'(bit_cnt), 64'd0);
`endif
    ec = 0;
    exp_bits = 0;
    cur_locked = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: one expectation per sampled cycle.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check("locked", x.ph, x.cyc, 64'(locked), 64'(x.l));
        check("err", x.ph, x.cyc, 64'(err), 64'(x.e));
        check("err_cnt", x.ph, x.cyc, 64'(err_cnt), 64'(x.c));
        check("locked_s", x.ph, x.cyc, 64'(locked_s), 64'(x.l));
        check("err_cnt_s", x.ph, x.cyc, 64'(err_cnt_s), (x.c > 15) ? 64'd15 : 64'(x.c));
`ifdef PRBS_CHECKER_BITCNT_EN
        check("bit_cnt", x.ph, x.cyc, 64'(bit_cnt), 64'(x.bc));
`endif
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic b;
    logic inv;
    logic clr;
    int   v;
    // Reset state (outputs checked while rst is held from time zero).
    #1;
    check("por_locked", 0, 0, 64'(locked), 64'd0);
    check("por_err", 0, 0, 64'(err), 64'd0);
    check("por_err_cnt", 0, 0, 64'(err_cnt), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Phase 1: clean stream from seed 7F; lock after valid bit 23.
    phase = 1;
    for (int k = 1; k <= 1000; k++) begin
      b = gen_bit();
      step(b, 1'b1, 1'b0, (k >= 23), 1'b0);
    end

    // Phase 2: single-bit errors at 100, 300, 500.
    phase = 2;
    for (int k = 1; k <= 600; k++) begin
      inv = (k == 100) || (k == 300) || (k == 500);
      b = gen_bit() ^ inv;
      if (inv) ec++;
      step(b, 1'b1, 1'b0, 1'b1, inv);
    end

    // Phase 3: clear, then 8 consecutive errors drop lock; clean stream relocks after 23 bits.
    phase = 3;
    ec = 0;
    b = gen_bit();
    step(b, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int j = 1; j <= 8; j++) begin
      b = gen_bit() ^ 1'b1;
      ec++;
      step(b, 1'b1, 1'b0, (j < 8), 1'b1);
    end
    for (int k = 1; k <= 40; k++) begin
      b = gen_bit();
      step(b, 1'b1, 1'b0, (k >= 23), 1'b0);
    end
    @(negedge clk);
    #2;
    do_reset();

    // Phase 4: all-zero stream never leaves SEED.
    phase = 4;
    for (int k = 1; k <= 50; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    do_reset();

    // Phase 5: en low on alternate cycles; errors, clear-with-error, clear while en=0.
    phase = 5;
    v = 0;
    for (int i = 0; i < 200; i++) begin
      if ((i % 2) == 0) begin
        v++;
        inv = (v == 40) || (v == 60) || (v == 80) || (v == 90);
        clr = (v == 80);
        b = gen_bit() ^ inv;
        if (clr) ec = 0;
        else if (inv) ec++;
        step(b, 1'b1, clr, (v >= 23), inv);
      end else begin
        clr = (v == 90);
        if (clr) ec = 0;
        step(1'($urandom), 1'b0, clr, cur_locked, 1'b0);
      end
    end

    // Phase 6: an error every 10th bit (at most 7 per window) saturates the 4-bit counter.
    phase = 6;
    for (int k = 1; k <= 200; k++) begin
      inv = ((k % 10) == 0);
      b = gen_bit() ^ inv;
      if (inv) ec++;
      step(b, 1'b1, 1'b0, 1'b1, inv);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", phase, cyc, 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
